// File: rtl/spi_frame_parser.sv
// -----------------------------------------------------------------------------
// spi_frame_parser
//
// Parses the byte stream from the SPI byte assembler into framed write
// commands:  HEADER, CMD, ADDR, LEN, DATA[0..LEN-1], CSUM.
// Data bytes are buffered and only written to the register file once the
// checksum (8-bit wrapping sum of CMD, ADDR, LEN and all DATA bytes) matches.
// The SPI slave-select delimits frames. A malformed or truncated frame is
// discarded and reported through frame_err/err_code.
//
// Handshake: byte_valid is a one-cycle strobe qualifying byte_data. There is
// no back-pressure. A byte that arrives while a commit is in progress is
// dropped and reported on overrun.
//
// Error codes: 1 bad header, 2 bad command, 3 bad length, 4 bad checksum,
//              5 frame truncated by slave-select rising.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   byte_data  in   [7:0] assembled SPI byte
//   byte_valid in   strobe qualifying byte_data
//   cs_n       in   SPI slave-select (asynchronous, synchronized here)
//   wr_en      out  register write strobe
//   wr_addr    out  [7:0] write address
//   wr_data    out  [7:0] write data
//   frame_done out  pulse when a frame has been fully committed
//   frame_err  out  pulse when a frame is rejected
//   err_code   out  [2:0] cause of the last frame_err (held)
//   overrun    out  pulse when a byte is dropped during commit
//   busy       out  high whenever the FSM is not IDLE
//   dbg_state  out  [2:0] current FSM state, for observation
// -----------------------------------------------------------------------------
module spi_frame_parser #(
   parameter int unsigned P_MAX_LEN = 16,
   parameter logic [7:0]  P_HEADER  = 8'hA5,
   parameter logic [7:0]  P_CMD_WR  = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   input  logic       cs_n,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_done,
   output logic       frame_err,
   output logic [2:0] err_code,
   output logic       overrun,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int unsigned IW       = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
   localparam logic [7:0]  MAX_LEN8 = 8'(P_MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_ADDR    = 3'd2,
      S_LEN     = 3'd3,
      S_DATA    = 3'd4,
      S_CSUM    = 3'd5,
      S_COMMIT  = 3'd6,
      S_WAIT_CS = 3'd7
   } state_t;

   state_t     state, state_d;
   logic [2:0] err_d;

   // cs_n synchronizer; the third flop only serves rising-edge detection.
   logic cs_s1, cs_s2, cs_s3;
   logic cs_rise;

   logic [7:0] acc;
   logic [7:0] addr_q;
   logic [6:0] len_q;
   logic [6:0] idx;
   logic [6:0] cidx;
   logic [7:0] data_buf [P_MAX_LEN];

   logic       wr_en_d, frame_done_d, frame_err_d, overrun_d;
   logic [7:0] wr_addr_d, wr_data_d;
   logic [2:0] err_code_d;

   assign cs_rise   = cs_s2 & ~cs_s3;
   assign dbg_state = state;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state;
      err_d   = 3'd0;
      case (state)
         S_IDLE: begin
            if (byte_valid) begin
               if (byte_data == P_HEADER) state_d = S_CMD;
               else begin
                  err_d   = 3'd1;
                  state_d = S_WAIT_CS;
               end
            end
         end
         S_CMD: begin
            if (byte_valid) begin
               if (byte_data == P_CMD_WR) state_d = S_ADDR;
               else begin
                  err_d   = 3'd2;
                  state_d = S_WAIT_CS;
               end
            end
         end
         S_ADDR: begin
            if (byte_valid) state_d = S_LEN;
         end
         S_LEN: begin
            if (byte_valid) begin
               if (byte_data == 8'd0 || byte_data > MAX_LEN8) begin
                  err_d   = 3'd3;
                  state_d = S_WAIT_CS;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (byte_valid && idx == len_q - 7'd1) state_d = S_CSUM;
         end
         S_CSUM: begin
            if (byte_valid) begin
               if (byte_data == acc) state_d = S_COMMIT;
               else begin
                  err_d   = 3'd4;
                  state_d = S_WAIT_CS;
               end
            end
         end
         S_COMMIT: begin
            if (cidx == len_q) state_d = S_WAIT_CS;
         end
         S_WAIT_CS: begin
            if (cs_s2) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Slave-select rising mid-frame: the byte in this cycle has already been
      // evaluated above. Only a completed, verified checksum survives; anything
      // else (including that byte's own error) becomes a truncation.
      if (cs_rise && (state == S_CMD || state == S_ADDR || state == S_LEN ||
                      state == S_DATA || state == S_CSUM) &&
          state_d != S_COMMIT) begin
         err_d   = 3'd5;
         state_d = S_IDLE;
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr;
      wr_data_d    = wr_data;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code;
      overrun_d    = 1'b0;

      // The first write is issued straight from the checksum acceptance so
      // that writes occupy exactly the LEN cycles following the CSUM byte.
      if (state == S_CSUM && state_d == S_COMMIT) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_q;
         wr_data_d = data_buf[0];
      end

      if (state == S_COMMIT) begin
         if (cidx != len_q) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q + {1'b0, cidx};
            wr_data_d = data_buf[cidx[IW-1:0]];
         end else begin
            frame_done_d = 1'b1;
         end
         if (byte_valid) overrun_d = 1'b1;
      end

      if (err_d != 3'd0) begin
         frame_err_d = 1'b1;
         err_code_d  = err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= 8'd0;
         wr_data    <= 8'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= 3'd0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wr_en      <= wr_en_d;
         wr_addr    <= wr_addr_d;
         wr_data    <= wr_data_d;
         frame_done <= frame_done_d;
         frame_err  <= frame_err_d;
         err_code   <= err_code_d;
         overrun    <= overrun_d;
         busy       <= (state_d != S_IDLE);
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_s1  <= 1'b1;
         cs_s2  <= 1'b1;
         cs_s3  <= 1'b1;
         acc    <= 8'd0;
         addr_q <= 8'd0;
         len_q  <= 7'd0;
         idx    <= 7'd0;
         cidx   <= 7'd0;
      end else begin
         cs_s1 <= cs_n;
         cs_s2 <= cs_s1;
         cs_s3 <= cs_s2;
         case (state)
            S_IDLE: begin
               acc <= 8'd0;
               idx <= 7'd0;
            end
            S_CMD: begin
               if (byte_valid) acc <= acc + byte_data;
            end
            S_ADDR: begin
               if (byte_valid) begin
                  addr_q <= byte_data;
                  acc    <= acc + byte_data;
               end
            end
            S_LEN: begin
               // Only meaningful when the length is in range; out-of-range
               // values abandon the frame before len_q is ever used.
               if (byte_valid) begin
                  len_q <= byte_data[6:0];
                  acc   <= acc + byte_data;
               end
            end
            S_DATA: begin
               if (byte_valid) begin
                  acc <= acc + byte_data;
                  idx <= idx + 7'd1;
               end
            end
            S_CSUM: begin
               cidx <= 7'd1;
            end
            S_COMMIT: begin
               if (cidx != len_q) cidx <= cidx + 7'd1;
            end
            default: ;
         endcase
      end
   end

   // Frame buffer: plain storage, no reset needed.
   always_ff @(posedge clk) begin
      if (state == S_DATA && byte_valid) data_buf[idx[IW-1:0]] <= byte_data;
   end

endmodule

// File: tb/tb_spi_frame_parser.sv
// -----------------------------------------------------------------------------
// Testbench for spi_frame_parser: directed frames with hand-computed results.
// Inputs change 1 ns after a rising edge; outputs are checked at that point
// (after the edge that produced them) and writes are collected at negedge.
// -----------------------------------------------------------------------------
module tb_spi_frame_parser;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       cs_n;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_done;
   logic       frame_err;
   logic [2:0] err_code;
   logic       overrun;
   logic       busy;
   logic [2:0] dbg_state;

   int n_total = 0;
   int n_bad   = 0;

   // scoreboard
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [7:0]  tx_q[$];
   int          done_cnt;
   int          err_cnt;
   int          ovr_cnt;

   spi_frame_parser dut (
      .clk        (clk),
      .rst        (rst),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .cs_n       (cs_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .overrun    (overrun),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (wr_en)      got_q.push_back({wr_addr, wr_data});
      if (frame_done) done_cnt = done_cnt + 1;
      if (frame_err)  err_cnt  = err_cnt + 1;
      if (overrun)    ovr_cnt  = ovr_cnt + 1;
   end

   // ---------------------------------------------------------------- drivers
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_data  = b;
      byte_valid = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   // Sends tx_q with two idle cycles between bytes; returns one cycle after
   // the last byte so its response can be checked directly.
   task automatic send_tx();
      for (int i = 0; i < tx_q.size(); i++) begin
         if (i != 0) idle(2);
         send_byte(tx_q[i]);
      end
   endtask

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      ovr_cnt  = 0;
   endtask

   task automatic open_window();
      cs_n = 1'b0;
      idle(4);
      clear_sb();
   endtask

   task automatic close_window();
      cs_n = 1'b1;
      idle(5);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst        = 1'b1;
      cs_n       = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      idle(3);
      n_total++; if ({wr_en, frame_done, frame_err, overrun, busy} !== 5'b0) begin
         n_bad++; $display("FAIL reset_strobes: got %b want 00000", {wr_en, frame_done, frame_err, overrun, busy});
      end
      n_total++; if ({wr_addr, wr_data} !== 16'h0000) begin
         n_bad++; $display("FAIL reset_addr_data: got %h want 0000", {wr_addr, wr_data});
      end
      n_total++; if (err_code !== 3'd0) begin
         n_bad++; $display("FAIL reset_err_code: got %0d want 0", err_code);
      end
      n_total++; if (dbg_state !== 3'd0) begin
         n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state);
      end
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_valid_frame();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
      send_tx();
      n_total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h10, 8'h11}) begin
         n_bad++; $display("FAIL valid_write0: got en=%b %h=%h want en=1 10=11", wr_en, wr_addr, wr_data);
      end
      n_total++; if (busy !== 1'b1) begin
         n_bad++; $display("FAIL valid_busy: got %b want 1", busy);
      end
      idle(1);
      n_total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h11, 8'h22}) begin
         n_bad++; $display("FAIL valid_write1: got en=%b %h=%h want en=1 11=22", wr_en, wr_addr, wr_data);
      end
      idle(1);
      n_total++; if ({wr_en, frame_done} !== 2'b01) begin
         n_bad++; $display("FAIL valid_done: got en=%b done=%b want en=0 done=1", wr_en, frame_done);
      end
      idle(1);
      n_total++; if (frame_done !== 1'b0) begin
         n_bad++; $display("FAIL valid_done_pulse: got %b want 0", frame_done);
      end
      close_window();
      n_total++; if (err_cnt !== 0 || done_cnt !== 1 || got_q.size() !== 2) begin
         n_bad++; $display("FAIL valid_counts: got err=%0d done=%0d wr=%0d want 0 1 2", err_cnt, done_cnt, got_q.size());
      end
      n_total++; if (busy !== 1'b0) begin
         n_bad++; $display("FAIL valid_idle_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_addr_wrap();
      open_window();
      exp_q = '{16'hFFAA, 16'h00BB};
      tx_q  = '{8'hA5, 8'h01, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h67};
      send_tx();
      idle(4);
      n_total++; if (got_q.size() !== exp_q.size()) begin
         n_bad++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_total++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL wrap_write%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      n_total++; if (done_cnt !== 1) begin
         n_bad++; $display("FAIL wrap_done: got %0d want 1", done_cnt);
      end
      close_window();
   endtask

   task automatic test_bad_csum();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h10, 8'h02, 8'h11, 8'h22, 8'h47};
      send_tx();
      n_total++; if ({frame_err, err_code} !== {1'b1, 3'd4}) begin
         n_bad++; $display("FAIL csum_err: got err=%b code=%0d want 1 4", frame_err, err_code);
      end
      idle(5);
      n_total++; if (got_q.size() !== 0 || done_cnt !== 0) begin
         n_bad++; $display("FAIL csum_nowrite: got wr=%0d done=%0d want 0 0", got_q.size(), done_cnt);
      end
      n_total++; if ({frame_err, err_code} !== {1'b0, 3'd4}) begin
         n_bad++; $display("FAIL csum_code_held: got err=%b code=%0d want 0 4", frame_err, err_code);
      end
      close_window();
   endtask

   task automatic test_bad_header();
      open_window();
      tx_q = '{8'h5A};
      send_tx();
      n_total++; if ({frame_err, err_code} !== {1'b1, 3'd1}) begin
         n_bad++; $display("FAIL hdr_err: got err=%b code=%0d want 1 1", frame_err, err_code);
      end
      tx_q = '{8'h01, 8'h10};
      idle(2);
      send_tx();
      idle(2);
      n_total++; if (err_cnt !== 1 || dbg_state !== 3'd7) begin
         n_bad++; $display("FAIL hdr_ignore: got errs=%0d state=%0d want 1 7", err_cnt, dbg_state);
      end
      close_window();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h20, 8'h01, 8'h33, 8'h55};
      send_tx();
      idle(3);
      n_total++; if (got_q.size() !== 1 || got_q[0] !== 16'h2033) begin
         n_bad++; $display("FAIL hdr_recover: got n=%0d first=%h want 1 2033", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
      end
      close_window();
   endtask

   task automatic test_bad_len();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h10, 8'h00};
      send_tx();
      n_total++; if ({frame_err, err_code} !== {1'b1, 3'd3}) begin
         n_bad++; $display("FAIL len0_err: got err=%b code=%0d want 1 3", frame_err, err_code);
      end
      close_window();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h10, 8'h10};
      send_tx();
      n_total++; if (frame_err !== 1'b0 || dbg_state !== 3'd4) begin
         n_bad++; $display("FAIL len16_ok: got err=%b state=%0d want 0 4", frame_err, dbg_state);
      end
      close_window();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h10, 8'h11};
      send_tx();
      n_total++; if ({frame_err, err_code} !== {1'b1, 3'd3}) begin
         n_bad++; $display("FAIL len17_err: got err=%b code=%0d want 1 3", frame_err, err_code);
      end
      close_window();
   endtask

   task automatic test_truncation();
      int lat;
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h10};
      send_tx();
      cs_n = 1'b1;
      lat  = 0;
      for (int i = 1; i <= 8; i++) begin
         idle(1);
         if (frame_err) begin
            lat = i;
            break;
         end
      end
      n_total++; if (lat < 1 || lat > 3) begin
         n_bad++; $display("FAIL trunc_latency: got %0d want 1..3", lat);
      end
      n_total++; if (err_code !== 3'd5) begin
         n_bad++; $display("FAIL trunc_code: got %0d want 5", err_code);
      end
      n_total++; if (dbg_state !== 3'd0) begin
         n_bad++; $display("FAIL trunc_state: got %0d want 0", dbg_state);
      end
      idle(3);
   endtask

   task automatic test_overrun();
      open_window();
      exp_q = '{16'h4001, 16'h4102, 16'h4203, 16'h4304};
      tx_q  = '{8'hA5, 8'h01, 8'h40, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h4F};
      send_tx();
      send_byte(8'hEE);
      n_total++; if (overrun !== 1'b1) begin
         n_bad++; $display("FAIL ovr_pulse: got %b want 1", overrun);
      end
      idle(6);
      n_total++; if (got_q.size() !== exp_q.size() || ovr_cnt !== 1 || done_cnt !== 1) begin
         n_bad++; $display("FAIL ovr_counts: got wr=%0d ovr=%0d done=%0d want 4 1 1", got_q.size(), ovr_cnt, done_cnt);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_total++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL ovr_write%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
         end
      end
      close_window();
   endtask

   task automatic test_reset_mid_commit();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h50, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5F};
      send_tx();
      n_total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 8'h50, 8'h01}) begin
         n_bad++; $display("FAIL rstc_first: got en=%b %h=%h want en=1 50=01", wr_en, wr_addr, wr_data);
      end
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      n_total++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL rstc_stop: got en=%b busy=%b want 0 0", wr_en, busy);
      end
      idle(6);
      n_total++; if (got_q.size() !== 1 || done_cnt !== 0) begin
         n_bad++; $display("FAIL rstc_counts: got wr=%0d done=%0d want 1 0", got_q.size(), done_cnt);
      end
      close_window();
   endtask

   // Byte arriving in the same cycle as the synchronized cs_n rise.
   task automatic test_cs_collision();
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h60, 8'h01, 8'h77};
      send_tx();
      idle(1);
      cs_n = 1'b1;
      idle(2);
      send_byte(8'hD9);
      idle(4);
      n_total++; if (got_q.size() !== 1 || got_q[0] !== 16'h6077 || err_cnt !== 0 || done_cnt !== 1) begin
         n_bad++; $display("FAIL coll_good: got wr=%0d err=%0d done=%0d want 1 write 6077, 0 err, 1 done", got_q.size(), err_cnt, done_cnt);
      end
      idle(2);
      open_window();
      tx_q = '{8'hA5, 8'h01, 8'h60, 8'h01, 8'h77};
      send_tx();
      idle(1);
      cs_n = 1'b1;
      idle(2);
      send_byte(8'hD8);
      n_total++; if ({frame_err, err_code} !== {1'b1, 3'd5}) begin
         n_bad++; $display("FAIL coll_bad: got err=%b code=%0d want 1 5", frame_err, err_code);
      end
      idle(4);
      n_total++; if (got_q.size() !== 0 || err_cnt !== 1) begin
         n_bad++; $display("FAIL coll_bad_counts: got wr=%0d err=%0d want 0 1", got_q.size(), err_cnt);
      end
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      clear_sb();
      test_reset();
      test_valid_frame();
      test_addr_wrap();
      test_bad_csum();
      test_bad_header();
      test_bad_len();
      test_truncation();
      test_overrun();
      test_reset_mid_commit();
      test_cs_collision();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_frame_parser.md
# spi_frame_parser

Downstream consumer of the SPI byte assembler (`spi_process`) in the PL. It parses each 8-bit word into a framed write command: header, cmd, addr, len, data, checksum. The data is buffered internally and committed to a register-file write port only after the checksum verifies. Frames are delimited by the SPI slave-select; malformed or truncated frames are discarded and reported with an error code.

## Interface
Parameters:
- `P_MAX_LEN`, 16: maximum data bytes per frame (1..64); sizes the internal buffer.
- `P_HEADER`, 8'hA5: required first byte of a frame.
- `P_CMD_WR`, 8'h01: only accepted command value.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `byte_data`  in  8  assembled byte from the SPI assembler.
- `byte_valid`  in  1  one-cycle strobe; `byte_data` is valid when high.
- `cs_n`  in  1  SPI slave-select, asynchronous to `clk`; synchronized internally by 2 flops.
- `wr_en`  out  1  register write strobe.
- `wr_addr`  out  8  write address.
- `wr_data`  out  8  write data.
- `frame_done`  out  1  one-cycle pulse when a frame has been fully committed.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.
- `err_code`  out  3  error cause; updated with each `frame_err` and held until the next one.
- `overrun`  out  1  one-cycle pulse when a byte arrives during COMMIT and is dropped.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Frame byte order: `P_HEADER`, CMD, ADDR, LEN, DATA[0..LEN-1], CSUM.
- CSUM = (CMD + ADDR + LEN + ΣDATA) mod 256, computed with an 8-bit wrapping accumulator.
- FSM states: IDLE, CMD, ADDR, LEN, DATA, CSUM, COMMIT, WAIT_CS.
- IDLE:
  - `byte_valid` with `byte_data`==`P_HEADER` -> CMD.
  - Any other byte -> err 1 -> WAIT_CS.
- CMD: byte == `P_CMD_WR` -> ADDR; otherwise err 2 -> WAIT_CS.
- ADDR: latch the start address -> LEN.
- LEN:
  - LEN==0 or LEN>`P_MAX_LEN` -> err 3 -> WAIT_CS.
  - Otherwise latch LEN -> DATA.
- DATA: write each byte into buffer[idx], idx counts from 0; after byte LEN-1 -> CSUM.
- CSUM:
  - Byte == accumulator -> COMMIT.
  - Mismatch -> err 4 -> WAIT_CS.
  - No writes are issued for a rejected frame.
- COMMIT:
  - One write per cycle for i = 0..LEN-1: `wr_addr` = (ADDR+i) mod 256, `wr_data` = buffer[i].
  - After the last write: `frame_done` pulse -> WAIT_CS.
- WAIT_CS: ignore all bytes; go to IDLE on the first cycle the synchronized `cs_n` is high.
- Truncation: a synchronized `cs_n` rising edge while in CMD, ADDR, LEN, DATA or CSUM gives err 5 -> IDLE.
- A `cs_n` rise in IDLE, COMMIT or WAIT_CS is not an error. In COMMIT the commit always completes.
- Simultaneous `byte_valid` and synchronized `cs_n` rise: the byte is processed first.
  - If that byte completes a valid CSUM, the frame is committed.
  - Otherwise err 5 is raised; the byte's own error, if any, is superseded by code 5.
- `byte_valid` in COMMIT: the byte is dropped and `overrun` pulses; the commit continues unaffected.
- Bytes after CSUM within the same `cs_n` window are ignored (WAIT_CS).
- Accumulator and idx clear on every entry to IDLE.

## Timing
- Reset: state IDLE. All outputs are 0: `wr_en`, `wr_addr`, `wr_data`, `frame_done`, `frame_err`, `err_code`, `overrun`, `busy`. The synchronizer flops reset to 1.
- All outputs are registered.
- State updates in the cycle after the `byte_valid` cycle.
- CSUM byte accepted at cycle t:
  - `wr_en` is high on cycles t+1..t+LEN, with address and data valid on the same cycles.
  - `frame_done` pulses at t+LEN+1.
- Error from a byte at cycle t: `frame_err` pulses at t+1, with `err_code` valid from t+1.
- Truncation error: `frame_err` pulses 1 cycle after the synchronized edge, i.e. ≤3 `clk` after the raw `cs_n` rise.
- Byte spacing from the upstream stage is ≥8 SCLK periods (≥160 `clk` at 2.5 MHz SCLK), so COMMIT of up to 64 cycles never overruns in normal use.
- `rst` asserted mid-COMMIT: `wr_en` is 0 from the next cycle, and the remaining writes are never issued.

## Test plan
- Valid frame A5 01 10 02 11 22 46 with `cs_n` low:
  - `wr_en` on 2 consecutive cycles writing 0x10=0x11, 0x11=0x22.
  - `frame_done` one cycle later; no `frame_err`.
- Address wrap, frame A5 01 FF 02 AA BB 67: writes 0xFF=0xAA, 0x00=0xBB.
- Bad checksum, frame A5 01 10 02 11 22 47: `frame_err`, `err_code`=4, zero `wr_en` pulses.
- Header 5A then 01 10: `err_code`=1 after the first byte. The following bytes are ignored. After `cs_n` high then low, A5 01 20 01 33 55 writes 0x20=0x33.
- LEN=0 (A5 01 10 00) gives `err_code`=3. LEN=17 with default `P_MAX_LEN` gives `err_code`=3.
- Truncation: A5 01 10 then `cs_n` high gives `err_code`=5 within 3 `clk`. A byte during COMMIT gives an `overrun` pulse and all writes still issue. `rst` mid-COMMIT stops `wr_en` the next cycle.
